// File: rtl/data_memory_be.sv
// Byte-enabled RISC-V data memory with sub-word loads and stores, misalignment fault detection,
// and an optional sweep that zeroes the array after reset.
module data_memory_be #(
    parameter int unsigned DEPTH_WORDS    = 64,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WE,
    input  logic        RE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] A_DM,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        READY,
    output logic        FAULT,
    output logic        FAULT_STICKY
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic {CLEAR, IDLE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          sticky_q, sticky_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          legal, misaligned;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          store_en, clr_en;
    logic [31:0]   word, shifted;
    logic [15:0]   half;
    logic          unused_addr;

    // Upper address bits are deliberately ignored so addresses wrap.
    assign idx         = A_DM[AW+1:2];
    assign lane        = A_DM[1:0];
    assign unused_addr = ^A_DM[31:AW+2];

    assign READY        = (state_q == IDLE) & RST;
    assign FAULT_STICKY = sticky_q;

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        case (FUNCT3)
            3'b000: legal = 1'b1;
            3'b001: begin legal = 1'b1; misaligned = A_DM[0]; end
            3'b010: begin legal = 1'b1; misaligned = |A_DM[1:0]; end
            3'b100: legal = !WE;
            3'b101: begin legal = !WE; misaligned = A_DM[0]; end
            default: legal = 1'b0;
        endcase
        FAULT = READY & (WE | RE) & (!legal | misaligned);
    end

    always_comb begin
        be    = 4'b1111;
        wdata = WD;
        case (FUNCT3[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{WD[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WD[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = WD;
            end
        endcase
    end

    assign store_en = READY & WE & !FAULT;
    assign clr_en   = RST & (state_q == CLEAR);

    always_ff @(posedge CLK) begin
        if (clr_en) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (store_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign word    = mem_q[idx];
    assign shifted = word >> {lane, 3'b000};
    assign half    = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        RD = '0;
        if (READY && !FAULT) begin
            if (!RE) begin
                RD = word;
            end else begin
                case (FUNCT3)
                    3'b000:  RD = {{24{shifted[7]}}, shifted[7:0]};
                    3'b001:  RD = {{16{half[15]}}, half};
                    3'b100:  RD = {24'b0, shifted[7:0]};
                    3'b101:  RD = {16'b0, half};
                    default: RD = word;
                endcase
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        sticky_d  = sticky_q | FAULT;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == AW'(DEPTH_WORDS - 1)) state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_ptr_q <= '0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            sticky_q  <= sticky_d;
        end
    end

endmodule
